// File: rtl/ps2_pkg.sv
// Shared constants and decoder state encoding for the PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  function automatic logic is_shift(input logic [7:0] b);
    return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Keyboard-side inputs and key-event outputs of ps2_key_tracker, plus debug taps.
interface ps2_key_tracker_if;
  import ps2_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  // key_valid is a one-cycle strobe with no ready: the consumer must take
  // key_code/key_shift/key_ext in the cycle key_valid is high; they hold after.
  logic [7:0] key_code;
  logic       key_shift;
  logic       key_ext;
  logic       key_valid;
  logic       shift_level;
  logic       frame_err;
  state_e     dbg_state;
  logic [3:0] dbg_bit_cnt;

  modport master (
    input  ps2_clk, ps2_data,
    output key_code, key_shift, key_ext, key_valid, shift_level, frame_err,
    output dbg_state, dbg_bit_cnt
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_code, key_shift, key_ext, key_valid, shift_level, frame_err,
    input  dbg_state, dbg_bit_cnt
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizer, falling-edge sampling, 11-bit frame check
// and inactivity timeout. Emits one-cycle byte_stb / frame_err pulses.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err,
  output logic [3:0] bit_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_stb_q, byte_stb_d;
  logic                   frame_err_q, frame_err_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   clk_s, data_s, fall;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    fall        = clk_prev_q & ~clk_s;
    clk_prev_d  = clk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = to_cnt_q;

    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_q: [0]=start, [8:1]=data LSB first, [9]=parity; data_s is stop
        if (!shift_q[0] && data_s && (^shift_q[9:1])) begin
          byte_d     = shift_q[8:1];
          byte_stb_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (bit_cnt_q != 4'd0 || !data_s) begin
        // An idle-high sample never starts a frame, so a frame needs a real start bit.
        shift_d   = {data_s, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      byte_q      <= 8'h00;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign rx_byte   = byte_q;
  assign byte_stb  = byte_stb_q;
  assign frame_err = frame_err_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: decodes make/break/E0 prefixes and shift state into key events.
// Build option TYPEMATIC_FILTER_EN suppresses auto-repeat of the held key.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_tracker_if.master bus
);

  logic [7:0] rx_byte;
  logic       byte_stb;
  logic       rx_err;
  logic [3:0] bit_cnt;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .byte_stb (byte_stb),
    .frame_err(rx_err),
    .bit_cnt  (bit_cnt)
  );

  state_e     state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_shift_q, key_shift_d;
  logic       key_ext_q, key_ext_d;
  logic       key_valid_q, key_valid_d;
  logic       emit, emit_ext, suppress;

  always_comb begin
    state_d  = state_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    if (byte_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_BREAK)       state_d = ST_BRK;
          else if (rx_byte == PS2_EXT)    state_d = ST_EXT;
          else if (rx_byte == PS2_LSHIFT) lshift_d = 1'b1;
          else if (rx_byte == PS2_RSHIFT) rshift_d = 1'b1;
          else                            emit = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte == PS2_BREAK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_byte != PS2_EXT) begin
            // E0 12 / E0 59 are fake shifts the keyboard wraps around some keys.
            state_d  = ST_IDLE;
            emit     = !is_shift(rx_byte);
            emit_ext = 1'b1;
          end
        end
        ST_BRK: begin
          if (rx_byte == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (rx_byte != PS2_BREAK) begin
            state_d = ST_IDLE;
            if (rx_byte == PS2_LSHIFT) lshift_d = 1'b0;
            if (rx_byte == PS2_RSHIFT) rshift_d = 1'b0;
          end
        end
        default: begin
          state_d = (rx_byte == PS2_EXT) ? ST_EXT : ST_IDLE;
        end
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] last_make_q, last_make_d;
  logic       last_ext_q, last_ext_d;
  logic       release_stb, release_ext;

  always_comb begin
    release_stb = byte_stb && (rx_byte != PS2_EXT) &&
                  ((state_q == ST_EXT_BRK) ||
                   (state_q == ST_BRK && rx_byte != PS2_BREAK));
    release_ext = (state_q == ST_EXT_BRK);
    last_make_d = last_make_q;
    last_ext_d  = last_ext_q;
    suppress    = 1'b0;
    if (emit) begin
      if (rx_byte == last_make_q && emit_ext == last_ext_q) begin
        suppress = 1'b1;
      end else begin
        last_make_d = rx_byte;
        last_ext_d  = emit_ext;
      end
    end else if (release_stb && rx_byte == last_make_q && release_ext == last_ext_q) begin
      last_make_d = 8'h00;
      last_ext_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_make_q <= 8'h00;
      last_ext_q  <= 1'b0;
    end else begin
      last_make_q <= last_make_d;
      last_ext_q  <= last_ext_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    key_code_d  = key_code_q;
    key_shift_d = key_shift_q;
    key_ext_d   = key_ext_q;
    key_valid_d = emit && !suppress;
    if (emit && !suppress) begin
      key_code_d  = rx_byte;
      // Shift state before this byte; a shift byte never emits anyway.
      key_shift_d = lshift_q | rshift_q;
      key_ext_d   = emit_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      key_code_q  <= 8'h00;
      key_shift_q <= 1'b0;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      key_code_q  <= key_code_d;
      key_shift_q <= key_shift_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign bus.key_code    = key_code_q;
  assign bus.key_shift   = key_shift_q;
  assign bus.key_ext     = key_ext_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.shift_level = lshift_q | rshift_q;
  assign bus.frame_err   = rx_err;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed test-plan steps plus random key sequences
// checked against a prefix/shift reference model of the keyboard protocol.
module tb_ps2_key_tracker;
  import ps2_pkg::*;

  localparam int TO = 300;
`ifdef TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk;
  logic rst;
  ps2_key_tracker_if bus ();

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int exp_ferr = 0;
  int obs_rd = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  // reference model state
  bit m_l, m_r, m_brk, m_ext;
  logic [8:0] m_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_valid) obs_q.push_back({bus.key_shift, bus.key_ext, bus.key_code});
      if (bus.frame_err) ferr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_l = 0; m_r = 0; m_brk = 0; m_ext = 0; m_last = 9'h000;
    exp_q.delete();
  endtask

  task automatic model_make(input bit e, input logic [7:0] b);
    if (FILT && m_last == {e, b}) return;
    m_last = {e, b};
    exp_q.push_back({m_l | m_r, e, b});
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit sh;
    sh = (b == 8'h12) || (b == 8'h59);
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (m_brk) begin
      if (!(b == 8'hF0 && !m_ext)) begin
        if (!m_ext && b == 8'h12) m_l = 0;
        if (!m_ext && b == 8'h59) m_r = 0;
        if (FILT && m_last == {m_ext, b}) m_last = 9'h000;
        m_brk = 0; m_ext = 0;
      end
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (m_ext) begin
      if (!sh) model_make(1'b1, b);
      m_ext = 0;
    end else if (b == 8'h12) m_l = 1;
    else if (b == 8'h59) m_r = 1;
    else model_make(1'b0, b);
  endtask

  // drivers
  task automatic send_bits(input logic [10:0] bits, input int n);
    int half;
    half = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (half) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (half) @(posedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = ~(^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits(mk_frame(b, bad), 11);
    if (bad) exp_ferr++;
    else model_byte(b);
    repeat ($urandom_range(5, 30)) @(posedge clk);
  endtask

  // scoreboard
  task automatic check_events(input string tag);
    int n;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n = obs_q.size() - obs_rd;
    chk({tag, "_count"}, n, exp_q.size());
    while (exp_q.size() > 0) begin
      if (obs_rd < obs_q.size()) chk({tag, "_event"}, obs_q[obs_rd], exp_q[0]);
      obs_rd++;
      void'(exp_q.pop_front());
    end
    obs_rd = obs_q.size();
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_shift_level"}, bus.shift_level, m_l | m_r);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_key_code"}, bus.key_code, 0);
    chk({tag, "_key_shift"}, bus.key_shift, 0);
    chk({tag, "_key_ext"}, bus.key_ext, 0);
    chk({tag, "_key_valid"}, bus.key_valid, 0);
    chk({tag, "_shift_level"}, bus.shift_level, 0);
    chk({tag, "_frame_err"}, bus.frame_err, 0);
    chk({tag, "_state"}, bus.dbg_state, ST_IDLE);
    chk({tag, "_bit_cnt"}, bus.dbg_bit_cnt, 0);
  endtask

  logic [7:0] codes [10] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B, 8'h74, 8'h72, 8'h29, 8'h5A};

  initial begin
    int n0, op;
    logic [7:0] c;
    rst = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);

    // single make
    send_byte(8'h1C, 0);
    check_events("make_1c");

    // shifted key
    send_byte(8'h12, 0);
    check_events("lshift_on");
    chk("lshift_level", bus.shift_level, 1);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    send_byte(8'hF0, 0); send_byte(8'h12, 0);
    check_events("shifted_a");
    chk("shift_released", bus.shift_level, 0);

    // extended make and break
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    check_events("ext_make");
    chk("ext_flag", bus.key_ext, 1);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    check_events("ext_break");

    // parity error then recovery
    send_byte(8'h1C, 1);
    check_events("bad_parity");
    send_byte(8'h1B, 0);
    check_events("after_bad");
    chk("after_bad_code", bus.key_code, 8'h1B);

    // timeout on a partial frame
    send_bits(mk_frame(8'h55, 0), 4);
    repeat (TO / 2) @(posedge clk);
    @(negedge clk);
    chk("partial_bit_cnt", bus.dbg_bit_cnt, 4);
    chk("partial_no_err", ferr_cnt, exp_ferr);
    repeat (TO) @(posedge clk);
    exp_ferr++;
    check_events("timeout");
    chk("timeout_bit_cnt", bus.dbg_bit_cnt, 0);
    send_byte(8'h29, 0);
    check_events("after_timeout");
    chk("after_timeout_code", bus.key_code, 8'h29);

    // auto-repeat
    n0 = obs_q.size();
    send_byte(8'h1C, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
    repeat (8) @(posedge clk);
    chk("typematic_count", obs_q.size() - n0, FILT ? 1 : 3);
    check_events("typematic");
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    check_events("typematic_release");

    // random key sequences
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      c = codes[$urandom_range(0, 9)];
      case (op)
        0, 1: send_byte(c, 0);
        2: begin send_byte(8'hF0, 0); send_byte(c, 0); end
        3: begin send_byte(8'hE0, 0); send_byte(c, 0); end
        4: begin send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(c, 0); end
        5: send_byte($urandom_range(0, 1) ? 8'h12 : 8'h59, 0);
        6: begin send_byte(8'hF0, 0); send_byte($urandom_range(0, 1) ? 8'h12 : 8'h59, 0); end
        7: begin send_byte(8'hE0, 0); send_byte(8'h12, 0); end
        8: send_byte(c, 1);
        default: begin send_byte(8'hF0, 0); send_byte(8'hF0, 0); send_byte(c, 0); end
      endcase
      check_events("random");
    end

    // reset mid-frame with shift held
    send_byte(8'h59, 0);
    check_events("rshift_on");
    send_bits(mk_frame(8'h1C, 0), 5);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_zero("mid_reset");
    model_reset();
    @(negedge clk) rst = 1'b0;
    obs_rd = obs_q.size();
    repeat (5) @(posedge clk);
    send_byte(8'h2B, 0);
    check_events("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
